// File: rtl/heater_pkg.sv
// Shared definitions for the water-heater thermostat sequencer.
// Covers state encodings, the sensor's valid Q12.4 range and a range-check helper.
package heater_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_WAIT_MEAS = 3'd2,
    ST_EVALUATE  = 3'd3,
    ST_HOLD      = 3'd4,
    ST_FAULTED   = 3'd5
  } state_t;

  // DS18B20 conversion range, signed Q12.4: -55 C .. +125 C
  localparam logic [15:0] TEMP_MIN = 16'hFC90;
  localparam logic [15:0] TEMP_MAX = 16'h07D0;

  function automatic logic temp_in_range(input logic [15:0] t);
    return ($signed(t) >= $signed(TEMP_MIN)) && ($signed(t) <= $signed(TEMP_MAX));
  endfunction

endpackage

// File: rtl/hc_hysteresis_cmp.sv
// Combinational thermostat comparisons on a Q12.4 sample.
// The lower threshold is widened to 17 bits so SETPOINT-HYST can never wrap.
module hc_hysteresis_cmp #(
  parameter logic [15:0] MAX_TEMP = 16'h0500
) (
  input  logic [15:0] temp,
  input  logic [15:0] setpoint,
  input  logic [7:0]  hyst,
  output logic        want_on,
  output logic        want_off,
  output logic        over_temp
);

  logic signed [16:0] temp_x;
  logic signed [16:0] setpoint_x;
  logic signed [16:0] low_x;

  assign temp_x     = {temp[15], temp};
  assign setpoint_x = {setpoint[15], setpoint};
  assign low_x      = setpoint_x - $signed({9'd0, hyst});

  assign want_on   = temp_x < low_x;
  assign want_off  = temp_x >= setpoint_x;
  assign over_temp = $signed(temp) >= $signed(MAX_TEMP);

endmodule

// File: rtl/heater_controller.sv
// Closed-loop thermostat sequencer: polls the one-wire sensor master, validates
// samples and drives the heater relay with hysteresis, dwell and over-temp cut-off.
//
// state      | meaning
// IDLE       | parked, relay open, waiting for ENABLE
// REQUEST    | one-cycle MEAS_REQ, restart timeout and sample period
// WAIT_MEAS  | waiting for MEAS_DONE / MEAS_ERR or timeout
// EVALUATE   | apply a good sample to the relay, or account a bad one
// HOLD       | wait out the rest of the sample period
// FAULTED    | sensor failed repeatedly, relay open until ENABLE drops
module heater_controller
  import heater_pkg::*;
#(
  parameter int unsigned SAMPLE_CYC    = 27_000_000,
  parameter int unsigned TIMEOUT_CYC   = 27_000_000,
  parameter int unsigned MIN_DWELL_CYC = 270_000_000,
  parameter int unsigned FAIL_LIMIT    = 3,
  parameter logic [15:0] MAX_TEMP      = 16'h0500
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic [15:0] SETPOINT,
  input  logic [7:0]  HYST,
  output logic        MEAS_REQ,
  input  logic        MEAS_DONE,
  input  logic        MEAS_ERR,
  input  logic [15:0] TEMP_IN,
  output logic [15:0] TEMP_LATCHED,
  output logic        HEATER_ON,
  output logic        FAULT,
  output logic [2:0]  STATE
);

  state_t      state_q, next_state;
  logic        meas_req_q;
  logic        heater_on_q, heater_nxt;
  logic        fault_q, fault_nxt;
  logic [15:0] temp_latched_q;
  logic [15:0] sample_q;
  logic        sample_ok_q;
  logic [31:0] tmo_cnt_q;
  logic [31:0] per_cnt_q;
  logic [31:0] dwell_cnt_q;
  logic [31:0] fail_cnt_q;

  logic capture_en;
  logic bad_en;
  logic fail_clr;
  logic latch_en;
  logic timeout;
  logic dwell_met;
  logic want_on, want_off, over_temp;

  hc_hysteresis_cmp #(
    .MAX_TEMP (MAX_TEMP)
  ) u_cmp (
    .temp      (sample_q),
    .setpoint  (SETPOINT),
    .hyst      (HYST),
    .want_on   (want_on),
    .want_off  (want_off),
    .over_temp (over_temp)
  );

  assign timeout   = tmo_cnt_q >= (TIMEOUT_CYC - 1);
  assign dwell_met = dwell_cnt_q >= MIN_DWELL_CYC;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  always_comb begin
    next_state = state_q;
    heater_nxt = heater_on_q;
    fault_nxt  = fault_q;
    capture_en = 1'b0;
    bad_en     = 1'b0;
    fail_clr   = 1'b0;
    latch_en   = 1'b0;
    if (!ENABLE) begin
      // Disabling parks from anywhere and drops any in-flight measurement.
      next_state = ST_IDLE;
      heater_nxt = 1'b0;
      fault_nxt  = 1'b0;
      fail_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          heater_nxt = 1'b0;
          next_state = ST_REQUEST;
        end
        ST_REQUEST: begin
          next_state = ST_WAIT_MEAS;
        end
        ST_WAIT_MEAS: begin
          if (MEAS_ERR || timeout) begin
            bad_en     = 1'b1;
            next_state = ST_EVALUATE;
          end else if (MEAS_DONE) begin
            next_state = ST_EVALUATE;
            if (temp_in_range(TEMP_IN)) begin
              capture_en = 1'b1;
            end else begin
              bad_en = 1'b1;
            end
          end
        end
        ST_EVALUATE: begin
          if (sample_ok_q) begin
            fail_clr   = 1'b1;
            latch_en   = 1'b1;
            next_state = ST_HOLD;
            if (over_temp) begin
              heater_nxt = 1'b0;
            end else if (dwell_met) begin
              if (!heater_on_q && want_on) begin
                heater_nxt = 1'b1;
              end else if (heater_on_q && want_off) begin
                heater_nxt = 1'b0;
              end
            end
          end else if (fail_cnt_q >= FAIL_LIMIT) begin
            next_state = ST_FAULTED;
            heater_nxt = 1'b0;
            fault_nxt  = 1'b1;
          end else begin
            next_state = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (per_cnt_q >= (SAMPLE_CYC - 1)) begin
            next_state = ST_REQUEST;
          end
        end
        ST_FAULTED: begin
          heater_nxt = 1'b0;
          fault_nxt  = 1'b1;
        end
        default: begin
          next_state = ST_IDLE;
          heater_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meas_req_q     <= 1'b0;
      heater_on_q    <= 1'b0;
      fault_q        <= 1'b0;
      temp_latched_q <= 16'h0000;
    end else begin
      meas_req_q  <= (next_state == ST_REQUEST);
      heater_on_q <= heater_nxt;
      fault_q     <= fault_nxt;
      if (latch_en) begin
        temp_latched_q <= sample_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sample_q    <= 16'h0000;
      sample_ok_q <= 1'b0;
    end else if (capture_en) begin
      sample_q    <= TEMP_IN;
      sample_ok_q <= 1'b1;
    end else if (bad_en) begin
      sample_ok_q <= 1'b0;
    end
  end

  // per_cnt counts cycles since the REQUEST cycle, so the REQUEST cycle itself is 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt_q <= '0;
      per_cnt_q <= '0;
    end else if (state_q == ST_REQUEST) begin
      tmo_cnt_q <= '0;
      per_cnt_q <= 32'd1;
    end else begin
      if (state_q == ST_WAIT_MEAS && tmo_cnt_q != '1) begin
        tmo_cnt_q <= tmo_cnt_q + 32'd1;
      end
      if (per_cnt_q != '1) begin
        per_cnt_q <= per_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dwell_cnt_q <= MIN_DWELL_CYC;
    end else if (heater_nxt != heater_on_q) begin
      dwell_cnt_q <= '0;
    end else if (dwell_cnt_q < MIN_DWELL_CYC) begin
      dwell_cnt_q <= dwell_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fail_cnt_q <= '0;
    end else if (fail_clr) begin
      fail_cnt_q <= '0;
    end else if (bad_en && fail_cnt_q != '1) begin
      fail_cnt_q <= fail_cnt_q + 32'd1;
    end
  end

  assign MEAS_REQ     = meas_req_q;
  assign HEATER_ON    = heater_on_q;
  assign FAULT        = fault_q;
  assign TEMP_LATCHED = temp_latched_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_heater_controller.sv
// Directed bench for heater_controller: a timestamp-based reference model is
// compared every cycle, plus hand-computed literal checks for each scenario.
module tb_heater_controller;

  localparam int SAMPLE  = 100;
  localparam int TMO     = 50;
  localparam int DWELL   = 200;
  localparam int FAILS   = 3;
  localparam int SP_Q4   = 40 * 16;
  localparam int HY_Q4   = 16;
  localparam int MAX_Q4  = 80 * 16;
  localparam int MIN_Q4  = -55 * 16;
  localparam int HI_Q4   = 125 * 16;

  logic        CLK;
  logic        RST_N;
  logic        ENABLE;
  logic [15:0] SETPOINT;
  logic [7:0]  HYST;
  logic        MEAS_REQ;
  logic        MEAS_DONE;
  logic        MEAS_ERR;
  logic [15:0] TEMP_IN;
  logic [15:0] TEMP_LATCHED;
  logic        HEATER_ON;
  logic        FAULT;
  logic [2:0]  STATE;

  heater_controller #(
    .SAMPLE_CYC    (100),
    .TIMEOUT_CYC   (50),
    .MIN_DWELL_CYC (200),
    .FAIL_LIMIT    (3),
    .MAX_TEMP      (16'h0500)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .ENABLE       (ENABLE),
    .SETPOINT     (SETPOINT),
    .HYST         (HYST),
    .MEAS_REQ     (MEAS_REQ),
    .MEAS_DONE    (MEAS_DONE),
    .MEAS_ERR     (MEAS_ERR),
    .TEMP_IN      (TEMP_IN),
    .TEMP_LATCHED (TEMP_LATCHED),
    .HEATER_ON    (HEATER_ON),
    .FAULT        (FAULT),
    .STATE        (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int tb_cyc   = 0;
  logic run_cmp = 1'b1;

  always @(posedge CLK) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tb_cyc);
  endtask

  // Reference model: times are cycle indices; dwell is time since the relay last changed.
  typedef struct {
    logic [2:0]  st;
    logic        heater;
    logic        fault;
    logic [15:0] latched;
    logic [15:0] sample;
    logic        ok;
    int          fails;
    int          t_req;
    int          t_change;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.st = 3'd0; r.heater = 1'b0; r.fault = 1'b0; r.latched = 16'h0000;
    r.sample = 16'h0000; r.ok = 1'b0; r.fails = 0; r.t_req = 0;
    r.t_change = -1_000_000;
    return r;
  endfunction

  function automatic model_t step(input model_t c, input int now, input logic en,
                                  input logic done, input logic err, input logic [15:0] t);
    model_t n = c;
    int     ts;
    int     smp;
    logic   nh;
    ts  = int'($signed(t));
    smp = int'($signed(c.sample));
    nh  = c.heater;
    if (!en) begin
      if (c.heater) n.t_change = now + 1;
      n.st = 3'd0; n.heater = 1'b0; n.fault = 1'b0; n.fails = 0;
      return n;
    end
    case (c.st)
      3'd0: n.st = 3'd1;
      3'd1: begin n.st = 3'd2; n.t_req = now; end
      3'd2: begin
        if (err || (now - c.t_req) >= TMO) begin
          n.fails = c.fails + 1; n.ok = 1'b0; n.st = 3'd3;
        end else if (done) begin
          n.st = 3'd3;
          if (ts >= MIN_Q4 && ts <= HI_Q4) begin n.ok = 1'b1; n.sample = t; end
          else begin n.ok = 1'b0; n.fails = c.fails + 1; end
        end
      end
      3'd3: begin
        if (c.ok) begin
          n.fails = 0; n.latched = c.sample; n.st = 3'd4;
          if (smp >= MAX_Q4) nh = 1'b0;
          else if ((now - c.t_change) >= DWELL) begin
            if (!c.heater && smp < SP_Q4 - HY_Q4) nh = 1'b1;
            else if (c.heater && smp >= SP_Q4) nh = 1'b0;
          end
          if (nh != c.heater) n.t_change = now + 1;
          n.heater = nh;
        end else if (c.fails >= FAILS) begin
          if (c.heater) n.t_change = now + 1;
          n.st = 3'd5; n.heater = 1'b0; n.fault = 1'b1;
        end else begin
          n.st = 3'd4;
        end
      end
      3'd4: if ((now - c.t_req) >= SAMPLE - 1) n.st = 3'd1;
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m <= model_reset();
    else m <= step(m, tb_cyc, ENABLE, MEAS_DONE, MEAS_ERR, TEMP_IN);
  end

  always @(negedge CLK) begin
    if (run_cmp) begin
      chk("cmp_state",   16'(STATE),     16'(m.st));
      chk("cmp_req",     16'(MEAS_REQ),  16'(m.st == 3'd1));
      chk("cmp_heater",  16'(HEATER_ON), 16'(m.heater));
      chk("cmp_fault",   16'(FAULT),     16'(m.fault));
      chk("cmp_latched", TEMP_LATCHED,   m.latched);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req(output int r);
    int n = 0;
    while (MEAS_REQ !== 1'b1 && n < 250) begin
      tick();
      n++;
    end
    chk("req_seen", 16'(MEAS_REQ), 16'd1);
    r = tb_cyc;
  endtask

  task automatic pulse(input int d, input logic done, input logic err, input logic [15:0] t);
    repeat (d) tick();
    MEAS_DONE = done;
    MEAS_ERR  = err;
    TEMP_IN   = t;
    tick();
    MEAS_DONE = 1'b0;
    MEAS_ERR  = 1'b0;
  endtask

  initial begin
    int r1, r2, r3, r;
    RST_N = 1'b0; ENABLE = 1'b1; MEAS_DONE = 1'b0; MEAS_ERR = 1'b0;
    TEMP_IN = 16'h0000; SETPOINT = 16'h0280; HYST = 8'd16;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_heater",  16'(HEATER_ON), 16'd0);
    chk("rst_state",   16'(STATE),     16'd0);
    chk("rst_latched", TEMP_LATCHED,   16'h0000);
    chk("rst_req",     16'(MEAS_REQ),  16'd0);
    chk("rst_fault",   16'(FAULT),     16'd0);
    RST_N = 1'b1;

    // 1: cold sample turns the heater on, period is 100 cycles
    wait_req(r1);
    pulse(10, 1'b1, 1'b0, 16'h0200);
    tick();
    chk("t1_heater_on", 16'(HEATER_ON), 16'd1);
    chk("t1_latched",   TEMP_LATCHED,   16'h0200);
    wait_req(r2);
    chk("t1_period", 16'(r2 - r1), 16'd100);

    // 2: warm samples at dwell 99 and 199 keep it on, 299 turns it off
    pulse(10, 1'b1, 1'b0, 16'h0290);
    tick();
    chk("t2_dwell99_on", 16'(HEATER_ON), 16'd1);
    chk("t2_latched",    TEMP_LATCHED,   16'h0290);
    wait_req(r);
    pulse(10, 1'b1, 1'b0, 16'h0290);
    tick();
    chk("t2_dwell199_on", 16'(HEATER_ON), 16'd1);
    wait_req(r);
    pulse(10, 1'b1, 1'b0, 16'h0290);
    tick();
    chk("t2_off", 16'(HEATER_ON), 16'd0);

    // 3: dwell blocks turn-on twice, then on, then over-temp cuts it at once
    for (int i = 0; i < 2; i++) begin
      wait_req(r);
      pulse(10, 1'b1, 1'b0, 16'h0200);
      tick();
      chk("t3_dwell_block", 16'(HEATER_ON), 16'd0);
    end
    wait_req(r);
    pulse(10, 1'b1, 1'b0, 16'h0200);
    tick();
    chk("t3_on", 16'(HEATER_ON), 16'd1);
    wait_req(r);
    pulse(10, 1'b1, 1'b0, 16'h0510);
    tick();
    chk("t3_overtemp_off", 16'(HEATER_ON), 16'd0);
    chk("t3_latched",      TEMP_LATCHED,   16'h0510);

    // 4: error, timeout, out-of-range -> fault
    wait_req(r);
    pulse(5, 1'b0, 1'b1, 16'h0000);
    tick();
    chk("t4_err_hold", 16'(STATE), 16'd4);
    wait_req(r2);
    repeat (50) tick();
    chk("t4_wait_last", 16'(STATE), 16'd2);
    tick();
    chk("t4_timeout", 16'(STATE), 16'd3);
    wait_req(r3);
    chk("t4_period", 16'(r3 - r2), 16'd100);
    pulse(10, 1'b1, 1'b0, 16'h0800);
    tick();
    chk("t4_fault",   16'(FAULT),     16'd1);
    chk("t4_heater",  16'(HEATER_ON), 16'd0);
    chk("t4_state",   16'(STATE),     16'd5);
    chk("t4_latched", TEMP_LATCHED,   16'h0510);
    repeat (120) tick();
    chk("t4_held", 16'(STATE), 16'd5);
    ENABLE = 1'b0;
    tick();
    chk("t4_clr_fault", 16'(FAULT), 16'd0);
    chk("t4_clr_state", 16'(STATE), 16'd0);
    ENABLE = 1'b1;

    // 5: simultaneous done+err is bad; stray done in HOLD ignored
    wait_req(r);
    pulse(10, 1'b1, 1'b1, 16'h0100);
    tick();
    chk("t5_latched", TEMP_LATCHED, 16'h0510);
    chk("t5_hold",    16'(STATE),   16'd4);
    repeat (7) tick();
    MEAS_DONE = 1'b1; TEMP_IN = 16'h0100;
    tick();
    MEAS_DONE = 1'b0;
    tick();
    tick();
    chk("t5_stray_latched", TEMP_LATCHED, 16'h0510);
    chk("t5_stray_state",   16'(STATE),   16'd4);
    wait_req(r);
    pulse(10, 1'b1, 1'b0, 16'h0200);
    tick();
    chk("t5_on", 16'(HEATER_ON), 16'd1);

    // 6: async reset mid-wait with the heater on
    wait_req(r);
    repeat (5) tick();
    chk("t6_pre_heater", 16'(HEATER_ON), 16'd1);
    #1 RST_N = 1'b0;
    #1;
    chk("t6_rst_heater", 16'(HEATER_ON), 16'd0);
    chk("t6_rst_state",  16'(STATE),     16'd0);
    tick();
    tick();
    RST_N = 1'b1;
    chk("t6_rel_req", 16'(MEAS_REQ), 16'd0);
    tick();
    chk("t6_first_req",   16'(MEAS_REQ), 16'd1);
    chk("t6_first_state", 16'(STATE),    16'd1);
    repeat (3) tick();

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
